// File: rtl/memory_access_unit.sv
// memory_access_unit
//   Memory-stage load/store sequencer. Serialises scalar (1-byte) and vector
//   (VEC_BYTES-byte) accesses onto a byte-wide data memory with one cycle of
//   synchronous read latency. The pipeline is held with `stall` until load
//   data is assembled or the vector store has been fully issued.
//
// Ports
//   clk                      sole clock, rising edge
//   reset                    asynchronous, active-low
//   req_valid                memory instruction present (sampled in IDLE only)
//   req_is_vector            1 = VEC_BYTES-byte access, 0 = byte access
//   req_is_store             1 = store, 0 = load
//   req_addr                 base byte address
//   store_data               scalar store byte
//   store_vector             vector store data, byte k in bits [8k+7:8k]
//   mem_addr/mem_we/mem_wdata  data memory request (combinational)
//   mem_rdata                read data, valid the cycle after mem_addr
//   stall                    freezes the pipeline
//   done                     one-cycle pulse when the access retires
//   data_from_memory         last scalar load result
//   vector_data_from_memory  last vector load result
//   dbg_state                current sequencer state (0 = IDLE, 1 = LD,
//                            2 = VLD, 3 = VST, 4 = DONE)
//
// Handshake: a request is taken in IDLE when req_valid is high. `stall` acts
// as the inverse of ready: while it is high the request shown must be held by
// the pipeline, but only the copy latched at acceptance is ever used. `done`
// marks the single cycle in which the access retires.
module memory_access_unit #(
  parameter int ADDR_W    = 10,
  parameter int VEC_BYTES = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  input  logic                   req_is_vector,
  input  logic                   req_is_store,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [7:0]             store_data,
  input  logic [8*VEC_BYTES-1:0] store_vector,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic                   mem_we,
  output logic [7:0]             mem_wdata,
  input  logic [7:0]             mem_rdata,
  output logic                   stall,
  output logic                   done,
  output logic [7:0]             data_from_memory,
  output logic [8*VEC_BYTES-1:0] vector_data_from_memory,
  output logic [2:0]             dbg_state
);

  localparam int VEC_W = 8 * VEC_BYTES;
  localparam int IDX_W = $clog2(VEC_BYTES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_BYTES - 1);
  localparam logic [IDX_W-1:0] END_IDX  = IDX_W'(VEC_BYTES);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LD   = 3'd1,
    S_VLD  = 3'd2,
    S_VST  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [VEC_W-1:0]   shadow_q, shadow_d;
  logic [7:0]         dfm_q, dfm_d;
  logic [VEC_W-1:0]   vdfm_q, vdfm_d;

  assign data_from_memory        = dfm_q;
  assign vector_data_from_memory = vdfm_q;
  assign dbg_state               = state_q;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      addr_q   <= '0;
      vec_q    <= '0;
      shadow_q <= '0;
      dfm_q    <= '0;
      vdfm_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      vec_q    <= vec_d;
      shadow_q <= shadow_d;
      dfm_q    <= dfm_d;
      vdfm_q   <= vdfm_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    vec_d    = vec_q;
    shadow_d = shadow_q;
    dfm_d    = dfm_q;
    vdfm_d   = vdfm_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          vec_d  = store_vector;
          idx_d  = '0;
          if (req_is_vector) begin
            // Byte 0 goes out this cycle, so the stream resumes at byte 1.
            idx_d   = IDX_W'(1);
            state_d = req_is_store ? S_VST : S_VLD;
          end else if (!req_is_store) begin
            state_d = S_LD;
          end
        end
      end
      S_LD: begin
        dfm_d   = mem_rdata;
        state_d = S_DONE;
      end
      S_VLD: begin
        // Read data lags the address by one cycle: it belongs to byte idx-1.
        for (int k = 0; k < VEC_BYTES; k++) begin
          if (idx_q == IDX_W'(k + 1)) shadow_d[8*k +: 8] = mem_rdata;
        end
        if (idx_q == END_IDX) begin
          // Publish the whole vector at once; a partial load never leaks out.
          vdfm_d  = shadow_d;
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_VST: begin
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = S_IDLE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Output logic. Reset forces every request output low immediately so an
  // aborted access stops driving the memory in the same instant.
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    stall     = 1'b0;
    done      = 1'b0;
    if (reset) begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            mem_addr = req_addr;
            if (!req_is_vector && req_is_store) begin
              mem_we    = 1'b1;
              mem_wdata = store_data;
              done      = 1'b1;
            end else begin
              stall = 1'b1;
              if (req_is_vector && req_is_store) begin
                mem_we    = 1'b1;
                mem_wdata = store_vector[7:0];
              end
            end
          end
        end
        S_LD: begin
          stall = 1'b1;
        end
        S_VLD: begin
          stall = 1'b1;
          if (idx_q <= LAST_IDX) mem_addr = addr_q + ADDR_W'(idx_q);
        end
        S_VST: begin
          mem_we   = 1'b1;
          mem_addr = addr_q + ADDR_W'(idx_q);
          for (int k = 0; k < VEC_BYTES; k++) begin
            if (idx_q == IDX_W'(k)) mem_wdata = vec_q[8*k +: 8];
          end
          stall = (idx_q < LAST_IDX);
          done  = (idx_q == LAST_IDX);
        end
        S_DONE: begin
          done = 1'b1;
        end
        default: begin
          mem_addr = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_unit.sv
module tb_memory_access_unit;

  localparam int ADDR_W = 10;
  localparam int MEM_SZ = 1 << ADDR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic              req_valid = 1'b0;
  logic              req_is_vector = 1'b0;
  logic              req_is_store = 1'b0;
  logic [9:0]        req_addr = '0;
  logic [7:0]        store_data = '0;
  logic [127:0]      store_vector = '0;
  logic [9:0]        mem_addr;
  logic              mem_we;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata = '0;
  logic              stall;
  logic              done;
  logic [7:0]        data_from_memory;
  logic [127:0]      vector_data_from_memory;
  logic [2:0]        dbg_state;

  memory_access_unit #(.ADDR_W(10), .VEC_BYTES(16)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .req_valid               (req_valid),
    .req_is_vector           (req_is_vector),
    .req_is_store            (req_is_store),
    .req_addr                (req_addr),
    .store_data              (store_data),
    .store_vector            (store_vector),
    .mem_addr                (mem_addr),
    .mem_we                  (mem_we),
    .mem_wdata               (mem_wdata),
    .mem_rdata               (mem_rdata),
    .stall                   (stall),
    .done                    (done),
    .data_from_memory        (data_from_memory),
    .vector_data_from_memory (vector_data_from_memory),
    .dbg_state               (dbg_state)
  );

  // ---------------- data memory (bench-owned) ----------------
  logic [7:0] mem [MEM_SZ];
  logic       preload = 1'b1;

  function automatic logic [7:0] pat(int i);
    if (i == 5) return 8'hA7;
    return 8'(i) ^ 8'h5A;
  endfunction

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < MEM_SZ; i++) mem[i] <= pat(i);
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic         stall;
    logic         done;
    logic         we;
    logic         chk_addr;
    logic [9:0]   addr;
    logic [7:0]   wdata;
    logic [7:0]   dfm;
    logic [127:0] vdfm;
  } exp_t;

  exp_t         exp_q[$];
  logic [7:0]   ref_mem [MEM_SZ];
  logic [7:0]   mdl_dfm = '0;
  logic [127:0] mdl_vdfm = '0;

  int n_checks = 0;
  int n_fail = 0;
  int stall_seen = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void push(bit st, bit dn, bit we, bit ca, logic [9:0] ad, logic [7:0] wd);
    exp_t e;
    e.stall = st; e.done = dn; e.we = we; e.chk_addr = ca;
    e.addr = ad; e.wdata = wd; e.dfm = mdl_dfm; e.vdfm = mdl_vdfm;
    exp_q.push_back(e);
  endfunction

  // ---------------- scoreboard compare ----------------
  always @(negedge clk) begin
    exp_t e;
    if (reset && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("stall", 128'(stall), 128'(e.stall));
      check("done", 128'(done), 128'(e.done));
      check("mem_we", 128'(mem_we), 128'(e.we));
      if (e.chk_addr) check("mem_addr", 128'(mem_addr), 128'(e.addr));
      if (e.we) check("mem_wdata", 128'(mem_wdata), 128'(e.wdata));
      check("data_from_memory", 128'(data_from_memory), 128'(e.dfm));
      check("vector_data_from_memory", vector_data_from_memory, e.vdfm);
      if (stall) stall_seen++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_idle(input int n);
    for (int i = 0; i < n; i++) begin
      push(0, 0, 0, 1, '0, '0);
      @(posedge clk); #1;
    end
  endtask

  // Predicts the whole access from the rules, then drives it. With noise set,
  // req_valid toggles and the request fields change while the access runs.
  task automatic do_req(input bit vec, input bit st, input logic [9:0] a,
                        input logic [7:0] sd, input logic [127:0] sv,
                        input bit noise, input int stop_at);
    int n;
    logic [127:0] v;
    logic [9:0] ad;
    if (!vec && st) begin
      n = 1;
      push(0, 1, 1, 1, a, sd);
      ref_mem[a] = sd;
    end else if (!vec) begin
      n = 3;
      push(1, 0, 0, 1, a, '0);
      push(1, 0, 0, 0, '0, '0);
      mdl_dfm = ref_mem[a];
      push(0, 1, 0, 0, '0, '0);
    end else if (!st) begin
      n = 18;
      v = '0;
      for (int c = 0; c < 16; c++) begin
        ad = a + 10'(c);
        push(1, 0, 0, 1, ad, '0);
        v[8*c +: 8] = ref_mem[ad];
      end
      push(1, 0, 0, 0, '0, '0);
      mdl_vdfm = v;
      push(0, 1, 0, 0, '0, '0);
    end else begin
      n = 16;
      for (int c = 0; c < 16; c++) begin
        ad = a + 10'(c);
        push(c < 15, c == 15, 1, 1, ad, sv[8*c +: 8]);
        ref_mem[ad] = sv[8*c +: 8];
      end
    end
    req_is_vector = vec; req_is_store = st; req_addr = a;
    store_data = sd; store_vector = sv; req_valid = 1'b1;
    for (int c = 1; c < n; c++) begin
      @(posedge clk); #1;
      if (noise) begin
        req_valid = c[0];
        req_addr = ~a;
        req_is_store = 1'b1;
        store_vector = ~sv;
      end else begin
        req_valid = 1'b0;
      end
      if (c == stop_at) return;
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_is_store = 1'b0; req_is_vector = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  logic [127:0] ramp;
  int s0;
  int bad;

  initial begin
    for (int i = 0; i < MEM_SZ; i++) ref_mem[i] = pat(i);
    for (int k = 0; k < 16; k++) ramp[8*k +: 8] = 8'(k);

    #12;
    check("reset stall", 128'(stall), 128'(0));
    check("reset done", 128'(done), 128'(0));
    check("reset mem_we", 128'(mem_we), 128'(0));
    check("reset mem_addr", 128'(mem_addr), 128'(0));
    check("reset dfm", 128'(data_from_memory), 128'(0));
    check("reset vdfm", vector_data_from_memory, 128'(0));
    check("reset state idle", 128'(dbg_state), 128'(0));
    @(posedge clk); #1;
    preload = 1'b0;
    reset = 1'b1;
    do_idle(2);

    // Scalar load from 0x005 holding 0xA7.
    s0 = stall_seen;
    do_req(0, 0, 10'h005, 8'h00, '0, 0, -1);
    check("sload stall cycles", 128'(stall_seen - s0), 128'(2));
    check("sload data literal", 128'(data_from_memory), 128'(8'hA7));

    // Vector store of the byte ramp at 0x020, then read it back.
    s0 = stall_seen;
    do_req(1, 1, 10'h020, 8'h00, ramp, 0, -1);
    check("vstore stall cycles", 128'(stall_seen - s0), 128'(15));
    s0 = stall_seen;
    do_req(1, 0, 10'h020, 8'h00, '0, 0, -1);
    check("vload stall cycles", 128'(stall_seen - s0), 128'(17));
    check("vload ramp literal", vector_data_from_memory,
          128'h0F0E0D0C0B0A09080706050403020100);
    do_idle(1);

    // Vector load that wraps past the top of the address space.
    do_req(1, 0, 10'h3F8, 8'h00, '0, 0, -1);
    check("wrap byte0 from 0x3F8", 128'(vector_data_from_memory[7:0]), 128'(8'hA2));
    check("wrap byte8 from 0x000", 128'(vector_data_from_memory[71:64]), 128'(8'h5A));

    // Back-to-back scalar stores.
    do_req(0, 1, 10'h001, 8'h11, '0, 0, -1);
    do_req(0, 1, 10'h002, 8'h22, '0, 0, -1);
    do_idle(1);

    // Vector load while req_valid toggles and req_addr changes.
    do_req(1, 0, 10'h040, 8'h00, '0, 1, -1);
    do_idle(1);

    // Reset pulled low while the vector load is at idx 7.
    do_req(1, 0, 10'h100, 8'h00, '0, 0, 7);
    #2;
    reset = 1'b0;
    #1;
    check("abort stall", 128'(stall), 128'(0));
    check("abort done", 128'(done), 128'(0));
    check("abort mem_we", 128'(mem_we), 128'(0));
    check("abort mem_addr", 128'(mem_addr), 128'(0));
    check("abort dfm", 128'(data_from_memory), 128'(0));
    check("abort vdfm", vector_data_from_memory, 128'(0));
    exp_q.delete();
    mdl_dfm = '0;
    mdl_vdfm = '0;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    do_idle(1);
    s0 = stall_seen;
    do_req(1, 0, 10'h100, 8'h00, '0, 0, -1);
    check("reload stall cycles", 128'(stall_seen - s0), 128'(17));
    do_idle(2);

    // Final memory and queue state.
    check("scoreboard drained", 128'(exp_q.size()), 128'(0));
    for (int k = 0; k < 16; k++) check("mem ramp byte", 128'(mem[32 + k]), 128'(k));
    check("mem 0x001", 128'(mem[1]), 128'(8'h11));
    check("mem 0x002", 128'(mem[2]), 128'(8'h22));
    bad = 0;
    for (int i = 0; i < MEM_SZ; i++) if (mem[i] !== ref_mem[i]) bad++;
    check("memory image mismatches", 128'(bad), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Time limit: the sequence above needs only a few hundred cycles.
  initial begin
    #20000;
    $display("FAIL timeout: got no end of sequence expected finish before 20000");
    n_fail++;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

endmodule

// File: doc/memory_access_unit.md
# memory_access_unit

Memory-stage load/store sequencer that produces `data_from_memory` (8-bit) and `vector_data_from_memory` (128-bit) for the memory/writeback pipeline register. It serialises scalar and 16-byte vector accesses onto a byte-wide, synchronous-read data memory. It holds the pipeline with `stall` until load data is assembled or the vector store is fully issued.

## Interface
- `ADDR_W`, 10, data memory byte-address width
- `VEC_BYTES`, 16, bytes per vector; the vector width is `8*VEC_BYTES`
- `clk` in 1: sole clock, rising edge
- `reset` in 1: asynchronous, active-low
- `req_valid` in 1: a memory instruction is present in the memory stage
- `req_is_vector` in 1: 1 = 16-byte access, 0 = byte access
- `req_is_store` in 1: 1 = store, 0 = load
- `req_addr` in ADDR_W: base byte address
- `store_data` in 8: scalar store byte
- `store_vector` in 128: vector store data
- `mem_addr` out ADDR_W: data memory address
- `mem_we` out 1: data memory write enable
- `mem_wdata` out 8: data memory write byte
- `mem_rdata` in 8: read data, valid the cycle after `mem_addr`
- `stall` out 1: freezes the pipeline, including the memory/writeback register
- `done` out 1: one-cycle pulse in the cycle the access retires
- `data_from_memory` out 8: last scalar load result
- `vector_data_from_memory` out 128: last vector load result

## Operation
- States: IDLE, LD (scalar capture), VLD (vector load stream), VST (vector store stream), DONE.
- Byte k of a vector maps to bits [8k+7:8k] at address `req_addr + k`, taken modulo 2^ADDR_W (wrap-around permitted).
- IDLE with `req_valid`=0: `mem_addr`=0, `mem_we`=0, `stall`=0, `done`=0.
- IDLE with `req_valid`=1: the unit latches `req_addr`, `store_vector` and the op type, then issues byte 0 combinationally that cycle.
- Scalar store: write `store_data` at `req_addr`. The unit stays in IDLE, with `stall`=0 and `done`=1 in that same cycle.
- Scalar load: issue the read and go to LD with `stall`=1. LD captures `mem_rdata` into `data_from_memory`, then goes to DONE.
- Vector load: issue byte 0 and go to VLD with idx=1.
  - Each VLD cycle issues byte idx (when idx ≤ 15) and captures `mem_rdata` into byte idx-1 of a shadow vector.
  - After capturing byte 15, the shadow vector is copied to `vector_data_from_memory`, and the unit goes to DONE.
- Vector store: write byte 0 and go to VST with idx=1. Each VST cycle writes byte idx from the latched vector.
  - `stall` drops in the cycle byte 15 is written.
  - That cycle asserts `done`, and the unit returns to IDLE.
- DONE: `stall`=0 and `done`=1, then return to IDLE. `req_valid` is ignored in DONE because the request shown is the retiring instruction.
- `req_valid` is ignored in every non-IDLE state. Request fields are used only from the latched copy.
- `data_from_memory` and `vector_data_from_memory` hold their values until the next load of the same kind. A partial vector load never modifies `vector_data_from_memory`.
- `stall` = (IDLE & `req_valid` & !(scalar store)) | LD | VLD | (VST & idx<15).

## Timing
- Reset (asynchronous, active-low): state IDLE, idx 0, and all of the following are 0: `data_from_memory`, `vector_data_from_memory`, shadow vector, `stall`, `done`, `mem_we`, `mem_addr`.
- Reset asserted mid-access aborts the access immediately. Bytes already written stay in memory. Outputs go to their reset values the same instant.
- Scalar store: 0 stall cycles, `done` in the issue cycle.
- Scalar load: stall cycles 0–1, `done` at cycle 2. Data is valid from cycle 2.
- Vector load: stall cycles 0–16, `done` at cycle 17. The vector updates atomically at the end of cycle 16.
- Vector store: stall cycles 0–14, with writes in cycles 0–15 and `done` at cycle 15.
- The next request can be accepted in IDLE on the cycle after `done`. A scalar store is the exception: it may follow a scalar store back-to-back.
- `mem_addr`, `mem_we` and `mem_wdata` are combinational from state and the latched request. `stall` is combinational from `req_valid` in IDLE.

## Test plan
- Scalar load from address 0x005 holding 0xA7 -> `stall` high for 2 cycles, `done` in cycle 2, `data_from_memory`=0xA7 from cycle 2.
- Vector store of 0x0F0E…0100 at 0x020, then a vector load from 0x020:
  - bytes 0x20–0x2F = 00…0F;
  - store stalls 15 cycles;
  - load stalls 17 cycles and returns 0x0F0E…0100.
- Vector load at 0x3F8 with ADDR_W=10 -> addresses 0x3F8–0x3FF, then 0x000–0x007, are read in order; byte 8 comes from address 0x000.
- Back-to-back scalar stores to 0x001 and 0x002 -> no stall, `done` high both cycles, both bytes written.
- Reset pulled low at VLD idx=7 -> `stall`, `done` and both outputs go to 0 at once; the next vector load completes normally in 17 stall cycles.
- `req_valid` toggled during a VLD, and `req_addr` changed -> the access proceeds using the latched address only, with no extra memory traffic.
